// File: rtl/fib_rpc_sequencer.sv
// fib_rpc_sequencer
//
// Call sequencer sitting between the RPC decoder/encoder streams and the
// `fib` compute core. One call is in flight at a time:
//   IDLE -> accept a tagged request (n, id)
//   CALL -> one-cycle start strobe to the core
//   WAIT -> acknowledge the core and count cycles until its result is valid
//   RESP -> present the tagged result until the encoder takes it
// Arguments whose Fibonacci number overflows 32-bit signed (n > MAX_N) are
// answered directly with an error response; the core is not started.
//
// Ports
//   clk, rst             : clock shared with the core, async active-high reset
//   i_n, i_id            : request argument (signed) and call tag
//   i_valid, i_ready     : request stream handshake
//   fib_ready, fib_in_n  : start strobe and argument to the core
//   fib_valid, fib_out_0 : result valid and result from the core
//   fib_accept           : result acknowledge to the core
//   o_data, o_id         : response result (signed) and echoed tag
//   o_error              : response is an out-of-range rejection
//   o_cycles             : number of WAIT cycles spent on the core (saturating)
//   o_valid, o_ready     : response stream handshake

module fib_rpc_sequencer #(
  parameter int ID_WIDTH  = 8,
  parameter int MAX_N     = 46,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [31:0]   i_n,
  input  logic [ID_WIDTH-1:0]  i_id,
  input  logic                 i_valid,
  output logic                 i_ready,
  output logic                 fib_ready,
  output logic signed [31:0]   fib_in_n,
  input  logic                 fib_valid,
  input  logic signed [31:0]   fib_out_0,
  output logic                 fib_accept,
  output logic signed [31:0]   o_data,
  output logic [ID_WIDTH-1:0]  o_id,
  output logic                 o_error,
  output logic [CNT_WIDTH-1:0] o_cycles,
  output logic                 o_valid,
  input  logic                 o_ready
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALL = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  localparam logic signed [31:0]   MAX_N_S = 32'(MAX_N);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  state_t                 state_r;
  state_t                 state_s;
  logic [CNT_WIDTH-1:0]   cnt_r;
  logic [CNT_WIDTH-1:0]   cnt_inc_s;
  logic                   over_s;

  // Out-of-range argument detect (signed compare) and saturating count.
  always_comb begin
    over_s = (i_n > MAX_N_S);
    if (cnt_r == CNT_MAX) begin
      cnt_inc_s = cnt_r;
    end else begin
      cnt_inc_s = cnt_r + CNT_ONE;
    end
  end

  // Input stream is only open while no call is in flight.
  assign i_ready = (state_r == ST_IDLE);

  // Next-state logic for the call sequence.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (i_valid) begin
          if (over_s) begin
            state_s = ST_RESP;
          end else begin
            state_s = ST_CALL;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CALL: begin
        state_s = ST_WAIT;
      end
      ST_WAIT: begin
        // fib_valid still carries the previous call's level until the CALL
        // strobe clears it, so it is only looked at here.
        if (fib_valid) begin
          state_s = ST_RESP;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (o_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RESP;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Registered handshake strobes, decoded from the state being entered so
  // they line up exactly with CALL, WAIT and RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fib_ready  <= 1'b0;
      fib_accept <= 1'b0;
      o_valid    <= 1'b0;
    end else begin
      fib_ready  <= (state_s == ST_CALL);
      fib_accept <= (state_s == ST_WAIT);
      o_valid    <= (state_s == ST_RESP);
    end
  end

  // Request capture, cycle counting and result capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fib_in_n <= 32'sd0;
      o_id     <= {ID_WIDTH{1'b0}};
      o_data   <= 32'sd0;
      o_error  <= 1'b0;
      o_cycles <= {CNT_WIDTH{1'b0}};
      cnt_r    <= {CNT_WIDTH{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (i_valid) begin
            fib_in_n <= i_n;
            o_id     <= i_id;
            cnt_r    <= {CNT_WIDTH{1'b0}};
            if (over_s) begin
              o_data   <= 32'sd0;
              o_error  <= 1'b1;
              o_cycles <= {CNT_WIDTH{1'b0}};
            end else begin
              o_error  <= 1'b0;
            end
          end
        end
        ST_WAIT: begin
          cnt_r <= cnt_inc_s;
          if (fib_valid) begin
            // The count reported includes the cycle the result arrived in.
            o_data   <= fib_out_0;
            o_cycles <= cnt_inc_s;
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

endmodule
